// File: rtl/logic_gates_pipe.sv
// logic_gates_pipe: registered WIDTH-bit two-input gate stage with runtime op
// select, optional accumulate mode (operand b taken from the accumulator),
// a 1-deep valid/ready output register, result flags and a delivered-result
// counter.
module logic_gates_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_par,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] res_cnt
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic             y_par_q, y_par_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] bo;
  logic [WIDTH-1:0] result;

  // The output slot is free when empty or being drained this cycle; never during reset.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  // A clear in the same cycle takes effect before the accumulator is used as operand.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign bo      = acc_mode ? acc_eff : b;

  // Bit-sliced gate array: every result bit depends only on the matching operand bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    // Select the gate function for this bit.
    always_comb begin
      result[gi] = 1'b0;
      case (op)
        OP_AND:  result[gi] = a[gi] & bo[gi];
        OP_OR:   result[gi] = a[gi] | bo[gi];
        OP_NOTA: result[gi] = ~a[gi];
        OP_NAND: result[gi] = ~(a[gi] & bo[gi]);
        OP_NOR:  result[gi] = ~(a[gi] | bo[gi]);
        OP_XOR:  result[gi] = a[gi] ^ bo[gi];
        OP_XNOR: result[gi] = ~(a[gi] ^ bo[gi]);
        OP_PASS: result[gi] = a[gi];
        default: result[gi] = 1'b0;
      endcase
    end
  end

  // Next-state for output register, flags, accumulator and delivery counter.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    y_zero_d    = y_zero_q;
    y_par_d     = y_par_q;
    acc_d       = acc_q;
    res_cnt_d   = res_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = result;
      y_zero_d    = (result == '0);
      y_par_d     = ^result;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    if (accept && acc_mode) begin
      acc_d = result;
    end else if (acc_clr) begin
      acc_d = '0;
    end

    if (deliver) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset that discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b1;
      y_par_q     <= 1'b0;
      acc_q       <= '0;
      res_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_par_q     <= y_par_d;
      acc_q       <= acc_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_par     = y_par_q;
  assign acc       = acc_q;
  assign res_cnt   = res_cnt_q;

endmodule

// File: doc/logic_gates_pipe.md
Name: logic_gates_pipe

Overview:
Parametrised, registered successor to the two-input gate set (AND/OR/NOT/NAND/NOR/XOR/XNOR). It works on WIDTH-bit vectors with a runtime op select and an optional accumulate mode that feeds the previous result back as operand b. It has a 1-deep output register with a valid/ready handshake, result flags (zero, parity) and a count of delivered results. It serves as the reusable logic datapath stage for later RTL blocks.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of delivered-result counter (wraps)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
a  in  WIDTH  operand a
b  in  WIDTH  operand b (ignored when acc_mode=1)
op  in  3  0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a
acc_mode  in  1  1: operand b := accumulator
acc_clr  in  1  clear accumulator (independent of handshake)
out_valid  out  1  y/flags hold a valid result
out_ready  in  1  downstream accepts result
y  out  WIDTH  registered result
y_zero  out  1  y == 0
y_par  out  1  XOR-reduction of y
acc  out  WIDTH  current accumulator value
res_cnt  out  CNT_W  number of results accepted downstream (out_valid&&out_ready)

Behaviour:
- Reset (rst=1 at edge): out_valid=0, y=0, y_zero=1, y_par=0, acc=0, res_cnt=0. Reset overrides everything, including a transaction in flight; the held result is discarded.
- in_ready = !out_valid || out_ready. The output is combinational from state and out_ready, and is 0 while rst is high.
- Accept: in_valid && in_ready at an edge. The result is loaded into y and out_valid=1. Latency is 1 cycle: the result is visible the cycle after accept.
- Effective operand: bo = acc_mode ? acc_eff : b, where acc_eff = acc_clr ? 0 : acc (clear is applied before use).
- Result by op:
  - 0: a&bo
  - 1: a|bo
  - 2: ~a
  - 3: ~(a&bo)
  - 4: ~(a|bo)
  - 5: a^bo
  - 6: ~(a^bo)
  - 7: a
  - All results are exactly WIDTH bits, with no extension.
- y_zero and y_par are registered together with y and always describe the current y.
- Output hold: while out_valid && !out_ready, y, flags and out_valid are frozen and no input is accepted.
- Drain: out_valid && out_ready && !accept gives out_valid=0 next cycle. y keeps its last value (don't-care).
- Simultaneous drain and accept gives full throughput, 1 result per cycle. out_valid stays 1 and y takes the new result.
- Accumulator update priority: rst > (accept && acc_mode) > acc_clr > hold.
  - Accept with acc_mode=1: acc := new result. If acc_clr is also high, the result was computed with bo=0 and acc still ends as that result.
  - acc_clr without such an accept: acc := 0.
  - Accept with acc_mode=0 leaves acc unchanged.
- res_cnt increments by 1 on each edge where out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- in_valid is ignored when in_ready=0; a/b/op may change freely then.
- X on inputs while in_valid=0 must not propagate into state.

Test Plan:
- WIDTH=8, a=0xF0, b=0xCC, out_ready=1, op 0..7 back-to-back -> y = 0xC0, 0xFC, 0x0F, 0x3F, 0x03, 0x3C, 0xC3, 0xF0 on consecutive cycles, each 1 cycle after accept; res_cnt=8.
- Backpressure: out_ready=0, send AND 0xFF/0x0F then OR 0x01/0x02 -> y=0x0F held and in_ready=0 for the second; raise out_ready -> 0x0F accepted, then y=0x03 next cycle.
- Accumulate: pulse acc_clr with accept, op=XOR, acc_mode=1, a=0x01, 0x02, 0x04 -> y=0x01, 0x03, 0x07, acc=0x07; then acc_clr alone -> acc=0x00, y unchanged.
- Flags: XOR a=0xAA, b=0xAA -> y=0x00, y_zero=1, y_par=0; AND a=0x07, b=0xFF -> y=0x07, y_zero=0, y_par=1.
- Reset mid-operation: out_valid=1, out_ready=0, acc=0x55, rst for 1 cycle -> out_valid=0, y=0, acc=0, res_cnt=0, in_ready=1 after rst falls.
- CNT_W=4: 17 results accepted downstream -> res_cnt reads 0 after the 16th and 1 after the 17th.
